// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one SRAM controller port between IF and LS
//
// Purpose: two requesters (instruction fetch, load/store) share a single SRAM
// controller port. One transaction at a time: IDLE -> GRANT_x -> RESP -> IDLE.
// A grant that sees no mem_ack for TIMEOUT cycles is aborted with a zero result
// and an err pulse.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   if_req/if_addr                instruction-fetch request (read-only)
//   if_rdata/if_ack               instruction-fetch response
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_bmask             load/store request
//   ls_rdata/ls_ack               load/store response (rdata is 0 for writes)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_bmask           request to the SRAM controller
//   mem_rdata/mem_ack             response from the SRAM controller
//   stall                         pipeline freeze while any request is unserved
//   err                           one-cycle pulse on timeout abort

module sram_port_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,

  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_bmask,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  ls_ack,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_bmask,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,

  output logic                  stall,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_LS = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  logic                  last_ls;   // 1: LS was granted most recently
  logic [7:0]            cnt;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   bmask_q;

  // IF wins a tie only when LS was served last.
  logic grant_if;
  logic grant_ls;
  logic timed_out;
  logic [DATA_W-1:0] result;

  assign grant_if  = if_req && (!ls_req || last_ls);
  assign grant_ls  = ls_req && !grant_if;
  // An ack in the final counted cycle takes priority over the abort.
  assign timed_out = !mem_ack && (cnt == CNT_LAST);
  assign result    = mem_ack ? mem_rdata : '0;

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_bmask = bmask_q;

  assign stall = (if_req & ~if_ack) | (ls_req & ~ls_ack);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      last_ls  <= 1'b0;
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      bmask_q  <= '0;
      mem_req  <= 1'b0;
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      err      <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_if) begin
            state   <= GRANT_IF;
            last_ls <= 1'b0;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
            wdata_q <= '0;
            bmask_q <= '1;
            mem_req <= 1'b1;
          end else if (grant_ls) begin
            state   <= GRANT_LS;
            last_ls <= 1'b1;
            cnt     <= '0;
            we_q    <= ls_we;
            addr_q  <= ls_addr;
            wdata_q <= ls_wdata;
            bmask_q <= ls_bmask;
            mem_req <= 1'b1;
          end
        end

        GRANT_IF, GRANT_LS: begin
          if (mem_ack || timed_out) begin
            state   <= RESP;
            mem_req <= 1'b0;
            err     <= timed_out;
            if (state == GRANT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= result;
            end else begin
              ls_ack   <= 1'b1;
              ls_rdata <= we_q ? '0 : result;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                rstn;
  logic                if_req;
  logic [ADDR_W-1:0]   if_addr;
  logic [DATA_W-1:0]   if_rdata;
  logic                if_ack;
  logic                ls_req;
  logic                ls_we;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W/8-1:0] ls_bmask;
  logic [DATA_W-1:0]   ls_rdata;
  logic                ls_ack;
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_bmask;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;
  logic                stall;
  logic                err;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_bmask(ls_bmask), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bmask(mem_bmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on negedges, so posedge+4 sees settled inputs and outputs.
  always @(posedge clk) begin
    #4;
    check("stall", stall, (if_req & ~if_ack) | (ls_req & ~ls_ack));
  end

  typedef struct {
    logic                is_ls;
    logic                we;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] bmask;
    int                  delay;      // GRANT cycles before mem_ack
    logic [DATA_W-1:0]   rdata;
    logic                exp_we;
    logic [DATA_W/8-1:0] exp_bmask;
    logic [DATA_W-1:0]   exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.is_ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata; ls_bmask = v.bmask;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    check("req_latency", mem_req, 1'b1);
    for (int i = 0; i <= v.delay; i++) begin
      check("grant_mem_req", mem_req, 1'b1);
      check("grant_mem_addr", mem_addr, v.addr);
      check("grant_mem_we", mem_we, v.exp_we);
      check("grant_mem_bmask", mem_bmask, v.exp_bmask);
      if (v.is_ls) check("grant_mem_wdata", mem_wdata, v.wdata);
      check("grant_if_ack", if_ack, 1'b0);
      check("grant_ls_ack", ls_ack, 1'b0);
      if (i == v.delay) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end else begin
        mem_rdata = ~v.rdata;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0; mem_rdata = 32'h0BAD0BAD;
    check("resp_mem_req", mem_req, 1'b0);
    check("resp_err", err, 1'b0);
    check("resp_own_ack", v.is_ls ? ls_ack : if_ack, 1'b1);
    check("resp_other_ack", v.is_ls ? if_ack : ls_ack, 1'b0);
    check("resp_rdata", v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    check("idle_own_ack", v.is_ls ? ls_ack : if_ack, 1'b0);
    check("idle_rdata_hold", v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
    check("idle_mem_req", mem_req, 1'b0);
  endtask

  logic grants[4];
  int   n_grants;
  int   req_cycles;

  initial begin
    //        is_ls we  addr        wdata         bmask delay rdata         exp_we bmask rdata
    vecs[0] = '{1'b0, 1'b0, 18'h00100, 32'h0,        4'h0, 2,  32'hDEADBEEF, 1'b0, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 18'h3FFFF, 32'h12345678, 4'h3, 0,  32'hAAAA5555, 1'b1, 4'h3, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 18'h00001, 32'hFFFFFFFF, 4'hF, 1,  32'hCAFEF00D, 1'b0, 4'hF, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 18'h2ABCD, 32'h0,        4'h0, 0,  32'h01234567, 1'b0, 4'hF, 32'h01234567};
    vecs[4] = '{1'b1, 1'b0, 18'h15A5A, 32'h0,        4'h5, 63, 32'h5A5A5A5A, 1'b0, 4'h5, 32'h5A5A5A5A};

    rstn = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_bmask = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_if_ack", if_ack, 1'b0);
    check("rst_ls_ack", ls_ack, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 18'h0);
    rstn = 1'b1;

    // Table-driven single transactions
    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // mem_ack in IDLE must do nothing
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFEEDFACE;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ack_mem_req", mem_req, 1'b0);
      check("idle_ack_if_ack", if_ack, 1'b0);
      check("idle_ack_ls_ack", ls_ack, 1'b0);
      check("idle_ack_err", err, 1'b0);
    end
    // mem_ack held through GRANT, RESP and the following IDLE
    if_req = 1'b1; if_addr = 18'h0F0F0;
    @(negedge clk);
    check("held_ack_grant", mem_req, 1'b1);
    @(negedge clk);
    check("held_ack_resp_if_ack", if_ack, 1'b1);
    check("held_ack_resp_rdata", if_rdata, 32'hFEEDFACE);
    if_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("resp_ack_if_ack", if_ack, 1'b0);
      check("resp_ack_ls_ack", ls_ack, 1'b0);
      check("resp_ack_mem_req", mem_req, 1'b0);
      check("resp_ack_err", err, 1'b0);
    end
    mem_ack = 1'b0;

    // Round robin after reset: LS, IF, LS, IF
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rr_rst_if_rdata", if_rdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    if_req = 1'b1; if_addr = 18'h11111;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 18'h22222; ls_bmask = 4'hF;
    mem_ack = 1'b1; mem_rdata = 32'h600DD00D;
    n_grants = 0;
    for (int k = 0; k < 20 && n_grants < 4; k++) begin
      @(negedge clk);
      if (mem_req) begin
        grants[n_grants] = (mem_addr == 18'h22222);
        n_grants++;
      end
    end
    check("rr_grant_count", n_grants, 4);
    for (int k = 0; k < 4; k++) check("rr_order", grants[k], (k % 2) == 0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    check("rr_last_ack", if_ack, 1'b1);
    mem_ack = 1'b0;
    @(negedge clk);

    // Timeout: mem_ack never comes
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 18'h0ABCD; ls_bmask = 4'hF;
    req_cycles = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      else if (req_cycles > 0) break;
    end
    check("to_req_cycles", req_cycles, TIMEOUT);
    check("to_err", err, 1'b1);
    check("to_ls_ack", ls_ack, 1'b1);
    check("to_ls_rdata", ls_rdata, 32'h0);
    check("to_if_ack", if_ack, 1'b0);
    ls_req = 1'b0;
    @(negedge clk);
    check("to_err_pulse", err, 1'b0);
    check("to_ack_pulse", ls_ack, 1'b0);
    check("to_idle_mem_req", mem_req, 1'b0);

    // Reset asserted mid GRANT_LS
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 18'h15555;
    @(negedge clk);
    check("mid_rst_grant", mem_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_async_mem_req", mem_req, 1'b0);
    check("mid_rst_ls_ack", ls_ack, 1'b0);
    @(negedge clk);
    check("mid_rst_no_ack", ls_ack, 1'b0);
    check("mid_rst_held_mem_req", mem_req, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_grant", mem_req, 1'b1);
    check("post_rst_addr", mem_addr, 18'h15555);
    mem_ack = 1'b1; mem_rdata = 32'h77778888;
    @(negedge clk);
    mem_ack = 1'b0;
    check("post_rst_ls_ack", ls_ack, 1'b1);
    check("post_rst_ls_rdata", ls_rdata, 32'h77778888);
    ls_req = 1'b0;
    @(negedge clk);
    check("post_rst_ack_pulse", ls_ack, 1'b0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
